// File: rtl/id_stage_controller.sv
// Decode-stage controller: owns the IF/ID and ID/EX pipeline registers, generates
// the sign-extended immediate, and resolves load-use stalls and branch flushes.
module id_stage_controller #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              if_valid,
   input  logic [31:0]       if_instr,
   input  logic [XLEN-1:0]   if_pc,
   input  logic              ex_branch_taken,
   output logic              if_ready,
   output logic              idex_valid,
   output logic [XLEN-1:0]   idex_pc,
   output logic [XLEN-1:0]   idex_imm,
   output logic [6:0]        idex_opcode,
   output logic [4:0]        idex_rs1,
   output logic [4:0]        idex_rs2,
   output logic [4:0]        idex_rd,
   output logic              idex_mem_read,
   output logic [CNT_W-1:0]  stall_count,
   output logic [CNT_W-1:0]  flush_count
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   logic              ifid_valid;
   logic [31:0]       ifid_instr;
   logic [XLEN-1:0]   ifid_pc;

   logic [6:0]        opcode;
   logic [4:0]        rs1;
   logic [4:0]        rs2;
   logic [4:0]        rd;
   logic [XLEN-1:0]   imm;
   logic              uses_rs1;
   logic              uses_rs2;
   logic              hazard;

   assign opcode = ifid_instr[6:0];
   assign rd     = ifid_instr[11:7];
   assign rs1    = ifid_instr[19:15];
   assign rs2    = ifid_instr[24:20];

   always_comb begin
      imm = '0;
      case (opcode)
         OP_LOAD, OP_IMM, OP_JALR:
            imm = {{(XLEN-12){ifid_instr[31]}}, ifid_instr[31:20]};
         OP_STORE:
            imm = {{(XLEN-12){ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
         OP_BRANCH:
            imm = {{(XLEN-13){ifid_instr[31]}}, ifid_instr[31], ifid_instr[7],
                   ifid_instr[30:25], ifid_instr[11:8], 1'b0};
         OP_JAL:
            imm = {{(XLEN-21){ifid_instr[31]}}, ifid_instr[31], ifid_instr[19:12],
                   ifid_instr[20], ifid_instr[30:21], 1'b0};
         OP_LUI, OP_AUIPC:
            imm = {{(XLEN-32){ifid_instr[31]}}, ifid_instr[31:12], 12'b0};
         default:
            imm = '0;
      endcase
   end

   always_comb begin
      uses_rs1 = !(opcode == OP_JAL || opcode == OP_LUI || opcode == OP_AUIPC);
      uses_rs2 = (opcode == OP_STORE || opcode == OP_BRANCH || opcode == OP_REG);
      hazard   = ifid_valid && idex_valid && idex_mem_read && (idex_rd != 5'd0) &&
                 ((uses_rs1 && idex_rd == rs1) || (uses_rs2 && idex_rd == rs2));
   end

   // Flush overrides a pending hazard, so fetch is never held during a squash.
   assign if_ready = reset || ex_branch_taken || !hazard;

   always_ff @(posedge clock) begin
      if (reset) begin
         ifid_valid    <= 1'b0;
         ifid_instr    <= '0;
         ifid_pc       <= '0;
         idex_valid    <= 1'b0;
         idex_pc       <= '0;
         idex_imm      <= '0;
         idex_opcode   <= '0;
         idex_rs1      <= '0;
         idex_rs2      <= '0;
         idex_rd       <= '0;
         idex_mem_read <= 1'b0;
         stall_count   <= '0;
         flush_count   <= '0;
      end else if (ex_branch_taken) begin
         ifid_valid    <= 1'b0;
         idex_valid    <= 1'b0;
         idex_pc       <= '0;
         idex_imm      <= '0;
         idex_opcode   <= '0;
         idex_rs1      <= '0;
         idex_rs2      <= '0;
         idex_rd       <= '0;
         idex_mem_read <= 1'b0;
         if (flush_count != '1)
            flush_count <= flush_count + CNT_W'(1);
      end else if (hazard) begin
         idex_valid    <= 1'b0;
         idex_pc       <= '0;
         idex_imm      <= '0;
         idex_opcode   <= '0;
         idex_rs1      <= '0;
         idex_rs2      <= '0;
         idex_rd       <= '0;
         idex_mem_read <= 1'b0;
         if (stall_count != '1)
            stall_count <= stall_count + CNT_W'(1);
      end else begin
         // An empty IF/ID slot advances as an all-zero bubble, never stale data.
         idex_valid    <= ifid_valid;
         idex_pc       <= ifid_valid ? ifid_pc : '0;
         idex_imm      <= ifid_valid ? imm : '0;
         idex_opcode   <= ifid_valid ? opcode : '0;
         idex_rs1      <= ifid_valid ? rs1 : '0;
         idex_rs2      <= ifid_valid ? rs2 : '0;
         idex_rd       <= ifid_valid ? rd : '0;
         idex_mem_read <= ifid_valid && (opcode == OP_LOAD);
         ifid_valid    <= if_valid;
         ifid_instr    <= if_instr;
         ifid_pc       <= if_pc;
      end
   end

endmodule

// File: tb/tb_id_stage_controller.sv
// Self-checking bench for id_stage_controller: directed scenarios plus randomized
// traffic compared against a rule-level pipeline model.
module tb_id_stage_controller;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        if_valid = 1'b0;
   logic [31:0] if_instr = '0;
   logic [63:0] if_pc = '0;
   logic        ex_branch_taken = 1'b0;

   logic        if_ready, idex_valid, idex_mem_read;
   logic [63:0] idex_pc, idex_imm;
   logic [6:0]  idex_opcode;
   logic [4:0]  idex_rs1, idex_rs2, idex_rd;
   logic [15:0] stall_count, flush_count;

   logic        s_if_ready, s_idex_valid, s_idex_mem_read;
   logic [63:0] s_idex_pc, s_idex_imm;
   logic [6:0]  s_idex_opcode;
   logic [4:0]  s_idex_rs1, s_idex_rs2, s_idex_rd;
   logic [1:0]  s_stall_count, s_flush_count;

   int n_checks = 0;
   int n_fail = 0;

   id_stage_controller #(.XLEN(64), .CNT_W(16)) dut (
      .clock(clock), .reset(reset), .if_valid(if_valid), .if_instr(if_instr),
      .if_pc(if_pc), .ex_branch_taken(ex_branch_taken), .if_ready(if_ready),
      .idex_valid(idex_valid), .idex_pc(idex_pc), .idex_imm(idex_imm),
      .idex_opcode(idex_opcode), .idex_rs1(idex_rs1), .idex_rs2(idex_rs2),
      .idex_rd(idex_rd), .idex_mem_read(idex_mem_read),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   id_stage_controller #(.XLEN(64), .CNT_W(2)) dut_small (
      .clock(clock), .reset(reset), .if_valid(if_valid), .if_instr(if_instr),
      .if_pc(if_pc), .ex_branch_taken(ex_branch_taken), .if_ready(s_if_ready),
      .idex_valid(s_idex_valid), .idex_pc(s_idex_pc), .idex_imm(s_idex_imm),
      .idex_opcode(s_idex_opcode), .idex_rs1(s_idex_rs1), .idex_rs2(s_idex_rs2),
      .idex_rd(s_idex_rd), .idex_mem_read(s_idex_mem_read),
      .stall_count(s_stall_count), .flush_count(s_flush_count)
   );

   always #5 clock = ~clock;

   // Reference model state: the two pipeline slots as plain variables.
   bit          m_ifid_valid;
   logic [31:0] m_ifid_instr;
   logic [63:0] m_ifid_pc;
   bit          m_ex_valid;
   logic [63:0] m_ex_pc, m_ex_imm;
   logic [6:0]  m_ex_op;
   logic [4:0]  m_ex_rs1, m_ex_rs2, m_ex_rd;
   bit          m_ex_mr;
   int          m_stalls, m_flushes;

   function automatic logic [63:0] ref_imm(input logic [31:0] i);
      case (i[6:0])
         7'h03, 7'h13, 7'h67: return longint'($signed(i[31:20]));
         7'h23: return longint'($signed({i[31:25], i[11:7]}));
         7'h63: return longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
         7'h6F: return longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
         7'h37, 7'h17: return longint'($signed({i[31:12], 12'h000}));
         default: return 64'd0;
      endcase
   endfunction

   function automatic bit ref_hazard();
      logic [6:0] op;
      bit u1, u2;
      op = m_ifid_instr[6:0];
      u1 = !(op == 7'h6F || op == 7'h37 || op == 7'h17);
      u2 = (op == 7'h23 || op == 7'h63 || op == 7'h33);
      return m_ifid_valid && m_ex_valid && m_ex_mr && m_ex_rd != 0 &&
             ((u1 && m_ex_rd == m_ifid_instr[19:15]) || (u2 && m_ex_rd == m_ifid_instr[24:20]));
   endfunction

   function automatic bit ref_ready();
      return reset || ex_branch_taken || !ref_hazard();
   endfunction

   function automatic int sat(input int n, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (n > mx) ? mx : n;
   endfunction

   task automatic zero_ex();
      m_ex_valid = 0; m_ex_pc = '0; m_ex_imm = '0; m_ex_op = '0;
      m_ex_rs1 = '0; m_ex_rs2 = '0; m_ex_rd = '0; m_ex_mr = 0;
   endtask

   // Advances the model by one cycle from the current inputs, then crosses the edge.
   task automatic tick();
      bit hz;
      hz = ref_hazard();
      if (reset) begin
         zero_ex();
         m_ifid_valid = 0; m_ifid_instr = '0; m_ifid_pc = '0;
         m_stalls = 0; m_flushes = 0;
      end else if (ex_branch_taken) begin
         zero_ex();
         m_ifid_valid = 0;
         m_flushes++;
      end else if (hz) begin
         zero_ex();
         m_stalls++;
      end else begin
         if (m_ifid_valid) begin
            m_ex_valid = 1;
            m_ex_pc    = m_ifid_pc;
            m_ex_imm   = ref_imm(m_ifid_instr);
            m_ex_op    = m_ifid_instr[6:0];
            m_ex_rs1   = m_ifid_instr[19:15];
            m_ex_rs2   = m_ifid_instr[24:20];
            m_ex_rd    = m_ifid_instr[11:7];
            m_ex_mr    = (m_ifid_instr[6:0] == 7'h03);
         end else begin
            zero_ex();
         end
         m_ifid_valid = if_valid; m_ifid_instr = if_instr; m_ifid_pc = if_pc;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic present(input bit v, input logic [31:0] ins, input logic [63:0] pc);
      if_valid = v; if_instr = ins; if_pc = pc;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      present(1, 32'hFFC0A283, 64'h40);
      #1;
      n_checks++;
      if (if_ready !== 1'b1) begin n_fail++; $display("FAIL reset_if_ready got=%b exp=1", if_ready); end
      tick(); tick();
      n_checks++;
      if ({idex_valid, idex_imm, stall_count, flush_count} !== '0) begin
         n_fail++;
         $display("FAIL reset_state got valid=%b imm=%h stall=%0d flush=%0d exp all 0",
                  idex_valid, idex_imm, stall_count, flush_count);
      end
      reset = 1'b0;
      present(1, 32'h0000B283, 64'h100);
      tick();
      n_checks++;
      if (idex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_latency1 got valid=%b exp=0", idex_valid); end
      present(0, '0, '0);
      tick();
      n_checks++;
      if (idex_valid !== 1'b1 || idex_pc !== 64'h100 || idex_mem_read !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_latency2 got valid=%b pc=%h mr=%b exp 1/100/1", idex_valid, idex_pc, idex_mem_read);
      end
      tick(); tick();
   endtask

   task automatic test_immediates();
      logic [31:0] ins [4];
      logic [63:0] exp [4];
      ins = '{32'hFFC0A283, 32'h0021B423, 32'hFE000CE3, 32'h001000EF};
      exp = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 64'hFFFF_FFFF_FFFF_FFF8, 64'h800};
      for (int i = 0; i < 5; i++) begin
         if (i < 4) present(1, ins[i], 64'h1000 + 64'(4 * i));
         else present(0, '0, '0);
         tick();
         if (i >= 1) begin
            n_checks++;
            if (idex_valid !== 1'b1 || idex_imm !== exp[i-1] || idex_pc !== 64'h1000 + 64'(4 * (i - 1))) begin
               n_fail++;
               $display("FAIL imm_%0d got valid=%b imm=%h pc=%h exp imm=%h", i - 1, idex_valid, idex_imm, idex_pc, exp[i-1]);
            end
         end
      end
      tick();
   endtask

   task automatic test_load_use();
      present(1, 32'h0000B283, 64'h2000);
      tick();
      present(1, 32'h00728333, 64'h2004);
      tick();
      #1;
      n_checks++;
      if (if_ready !== 1'b0) begin n_fail++; $display("FAIL load_use_ready got=%b exp=0", if_ready); end
      tick();
      n_checks++;
      if (idex_valid !== 1'b0 || idex_imm !== '0 || idex_rd !== '0 || stall_count !== 16'd1) begin
         n_fail++;
         $display("FAIL load_use_bubble got valid=%b imm=%h rd=%0d stall=%0d exp 0/0/0/1", idex_valid, idex_imm, idex_rd, stall_count);
      end
      n_checks++;
      if (if_ready !== 1'b1) begin n_fail++; $display("FAIL load_use_release got=%b exp=1", if_ready); end
      present(0, '0, '0);
      tick();
      n_checks++;
      if (idex_valid !== 1'b1 || idex_opcode !== 7'h33 || idex_rd !== 5'd6 || idex_pc !== 64'h2004) begin
         n_fail++;
         $display("FAIL load_use_add got valid=%b op=%h rd=%0d pc=%h exp 1/33/6/2004", idex_valid, idex_opcode, idex_rd, idex_pc);
      end
      tick();
   endtask

   task automatic test_no_false_stall();
      logic [31:0] seq [4];
      int bad;
      seq = '{32'h0000B003, 32'h00700333, 32'h0000B283, 32'h010000EF};
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         if (i < 4) present(1, seq[i], 64'h3000 + 64'(4 * i));
         else present(0, '0, '0);
         #1;
         if (if_ready !== 1'b1) bad++;
         tick();
      end
      n_checks++;
      if (bad != 0 || stall_count !== 16'd1) begin
         n_fail++;
         $display("FAIL no_false_stall got low_ready=%0d stall=%0d exp 0/1", bad, stall_count);
      end
      n_checks++;
      if (idex_valid !== 1'b0) begin n_fail++; $display("FAIL drain got valid=%b exp=0", idex_valid); end
   endtask

   task automatic test_flush_priority();
      present(1, 32'h0000B283, 64'h4000);
      tick();
      present(1, 32'h00728333, 64'h4004);
      tick();
      ex_branch_taken = 1'b1;
      #1;
      n_checks++;
      if (if_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got=%b exp=1", if_ready); end
      tick();
      ex_branch_taken = 1'b0;
      present(0, '0, '0);
      n_checks++;
      if (idex_valid !== 1'b0 || dut.ifid_valid !== 1'b0 || flush_count !== 16'd1 || stall_count !== 16'd1) begin
         n_fail++;
         $display("FAIL flush_priority got ex=%b ifid=%b flush=%0d stall=%0d exp 0/0/1/1",
                  idex_valid, dut.ifid_valid, flush_count, stall_count);
      end
      tick();
      n_checks++;
      if (idex_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped got valid=%b exp=0", idex_valid); end
   endtask

   task automatic test_saturation();
      ex_branch_taken = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      ex_branch_taken = 1'b0;
      n_checks++;
      if (s_flush_count !== 2'd3) begin n_fail++; $display("FAIL sat_small got=%0d exp=3", s_flush_count); end
      n_checks++;
      if (flush_count !== 16'd6) begin n_fail++; $display("FAIL sat_wide got=%0d exp=6", flush_count); end
   endtask

   task automatic test_random();
      logic [6:0] ops [10];
      logic [31:0] ins;
      ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33, 7'h0B};
      for (int c = 0; c < 400; c++) begin
         ins = $urandom;
         ins[6:0]   = ops[$urandom_range(9)];
         ins[11:7]  = 5'($urandom_range(3));
         ins[19:15] = 5'($urandom_range(3));
         ins[24:20] = 5'($urandom_range(3));
         present(($urandom_range(9) < 8), ins, {$urandom, $urandom});
         ex_branch_taken = ($urandom_range(9) == 0);
         reset = ($urandom_range(49) == 0);
         #1;
         n_checks++;
         if (if_ready !== ref_ready()) begin
            n_fail++;
            $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, if_ready, ref_ready());
         end
         tick();
         n_checks++;
         if ({idex_valid, idex_pc, idex_imm, idex_opcode, idex_rs1, idex_rs2, idex_rd, idex_mem_read} !==
             {m_ex_valid, m_ex_pc, m_ex_imm, m_ex_op, m_ex_rs1, m_ex_rs2, m_ex_rd, m_ex_mr}) begin
            n_fail++;
            $display("FAIL rand_idex cyc=%0d got v=%b pc=%h imm=%h op=%h rs=%0d,%0d rd=%0d mr=%b exp v=%b pc=%h imm=%h op=%h rs=%0d,%0d rd=%0d mr=%b",
                     c, idex_valid, idex_pc, idex_imm, idex_opcode, idex_rs1, idex_rs2, idex_rd, idex_mem_read,
                     m_ex_valid, m_ex_pc, m_ex_imm, m_ex_op, m_ex_rs1, m_ex_rs2, m_ex_rd, m_ex_mr);
         end
         n_checks++;
         if (stall_count !== 16'(sat(m_stalls, 16)) || flush_count !== 16'(sat(m_flushes, 16)) ||
             s_stall_count !== 2'(sat(m_stalls, 2)) || s_flush_count !== 2'(sat(m_flushes, 2))) begin
            n_fail++;
            $display("FAIL rand_counts cyc=%0d got stall=%0d flush=%0d small=%0d/%0d exp stall=%0d flush=%0d",
                     c, stall_count, flush_count, s_stall_count, s_flush_count, m_stalls, m_flushes);
         end
      end
      reset = 1'b0;
      ex_branch_taken = 1'b0;
   endtask

   initial begin
      zero_ex();
      m_ifid_valid = 0; m_ifid_instr = '0; m_ifid_pc = '0;
      m_stalls = 0; m_flushes = 0;
      test_reset();
      test_immediates();
      test_load_use();
      test_no_false_stall();
      test_flush_priority();
      test_saturation();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/id_stage_controller.md
Name: id_stage_controller

Overview:
- Owns the IF/ID and ID/EX pipeline registers of the 5-stage RV64 pipeline.
- Sequences decode: it generates the sign-extended immediate, detects load-use hazards, and issues stall or flush control.
- It decides each cycle whether the decode stage advances, holds, or is squashed, and drives the bubble into EX.
- Sits between the fetch unit and the execute stage; the EX stage supplies the branch-taken signal.

Parameters:
- XLEN, 64, datapath and immediate width
- CNT_W, 16, width of the saturating stall/flush event counters

Ports:
- clock  in  1  single system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- if_valid  in  1  fetch presents a valid instruction
- if_instr  in  32  fetched instruction
- if_pc  in  XLEN  PC of fetched instruction
- ex_branch_taken  in  1  EX resolved a taken branch or jump; squash younger stages
- if_ready  out  1  combinational; 0 means fetch must hold PC and instruction
- idex_valid  out  1  ID/EX holds a real instruction
- idex_pc  out  XLEN  registered PC
- idex_imm  out  XLEN  registered sign-extended immediate
- idex_opcode  out  7  registered opcode
- idex_rs1, idex_rs2, idex_rd  out  5 each  registered register indices
- idex_mem_read  out  1  registered; 1 when opcode is load (0000011) and valid
- stall_count  out  CNT_W  saturating count of load-use stall cycles
- flush_count  out  CNT_W  saturating count of flush cycles

Behaviour:
- Reset (synchronous, active-high, reset=1 at a rising edge):
  - ifid_valid, idex_valid and idex_mem_read are cleared.
  - All idex_* data and both counters go to 0.
  - if_ready=1 while reset is held.
  - Reset mid-operation discards all in-flight state in that same cycle.
- Immediate generation is combinational from the IF/ID instruction and registered into idex_imm.
  - Zero latency from decode to ID/EX; one cycle from fetch acceptance to idex_*.
  - I-type (0000011, 0010011, 1100111): sext(instr[31:20]).
  - S-type (0100011): sext({instr[31:25], instr[11:7]}).
  - B-type (1100011): sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - J-type (1101111): sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - U-type (0110111, 0010111): sext({instr[31:12], 12'b0}).
  - Any other opcode: 0.
  - Sign bit is always instr[31], extended to XLEN.
- Source usage:
  - uses_rs1 is true for all opcodes except 1101111, 0110111 and 0010111.
  - uses_rs2 is true only for 0100011, 1100011 and 0110011.
- Hazard is asserted when all of the following hold:
  - ifid_valid and idex_valid and idex_mem_read;
  - idex_rd != 0;
  - (uses_rs1 and idex_rd == rs1) or (uses_rs2 and idex_rd == rs2).
- Per-cycle priority is flush, then hazard, then advance.
  - FLUSH (ex_branch_taken=1):
    - ifid_valid <= 0 and idex_valid <= 0; ID/EX controls zeroed, idex_mem_read=0.
    - if_ready=1; flush_count increments.
    - An ongoing hazard is cancelled. The instruction presented by fetch in this cycle is dropped (wrong path).
  - STALL (hazard and no flush):
    - IF/ID holds its contents; ID/EX gets a bubble (idex_valid=0, idex_mem_read=0).
    - if_ready=0; stall_count increments.
    - A stall lasts exactly one cycle, because the bubble clears idex_mem_read.
  - ADVANCE:
    - ID/EX <= decode of IF/ID, with idex_valid=ifid_valid.
    - IF/ID <= {if_valid, if_instr, if_pc}.
    - if_ready=1.
- A bubble presents all idex_* data as 0, not stale values.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- rd=x0 never causes a stall.
- Back-to-back loads into a dependent consumer give one stall per dependent pair.

Test Plan:
- Reset: hold reset 2 cycles with if_valid=1 → idex_valid=0, idex_imm=0, counters=0, if_ready=1; first valid instruction appears on idex_* 2 cycles after reset release.
- Immediates: stream lw x5,-4(x1) (0xFFC0A283), sd x2,8(x3) (0x0021B423), beq x0,x0,-8 (0xFE000CE3), jal x1,2048 (0x001000EF) with no hazards → idex_imm = 0xFFFF_FFFF_FFFF_FFFC, 0x8, 0xFFFF_FFFF_FFFF_FFF8, 0x800, one per cycle.
- Load-use: ld x5,0(x1) followed by add x6,x5,x7 → exactly one cycle with if_ready=0 and idex_valid=0; add reaches ID/EX the next cycle; stall_count=1.
- No false stall: ld x0,0(x1) then add x6,x0,x7, and ld x5 then jal x1,16 → if_ready stays 1, stall_count stays 0.
- Flush priority: assert ex_branch_taken in the same cycle a load-use hazard is detected → both idex_valid and ifid_valid become 0, if_ready=1, flush_count=1, stall_count unchanged.
- Saturation: with CNT_W=2, force 5 consecutive flush cycles → flush_count=3.
